dac_sample_sequencer: RTL

Sample-playback controller for the 8-bit 3.3 V DAC macro. It buffers 8-bit codes written by the host (Wishbone-side register logic) in a small FIFO. It also sequences the DAC enable: enable, wait a programmable settling time, then stream samples at a programmable rate. Its outputs drive the DAC wrapper's `ena` and `data[7:0]` pins directly; the analog reference pins are outside its scope.

---
 rtl/dac_sample_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dac_sample_sequencer.sv
// DAC playback sequencer: sample FIFO, enable/settle sequencing
// and rate-divided streaming onto the DAC data pins.
module dac_sample_sequencer #(
  parameter int DEPTH    = 16,
  parameter int DIV_W    = 16,
  parameter int SETTLE_W = 8
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    cfg_en,
  input  logic [DIV_W-1:0]        cfg_div,
  input  logic [SETTLE_W-1:0]     cfg_settle,
  input  logic                    fifo_flush,
  input  logic                    wr_valid,
  input  logic [7:0]              wr_data,
  output logic                    wr_ready,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    dac_ena,
  output logic [7:0]              dac_data,
  output logic                    busy,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RUN
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [SETTLE_W-1:0]   r_settle_cnt;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [AW:0]           r_wptr;
  logic [AW:0]           r_rptr;
  logic [7:0]            r_mem [DEPTH];
  logic [7:0]            r_dac_data;
  logic                  r_underflow;

  logic [AW:0]           w_level;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_slot;
  logic                  w_push;
  logic                  w_pop;

  assign w_level = r_wptr - r_rptr;
  assign w_empty = (w_level == '0);
  assign w_full  = (w_level == (AW+1)'(DEPTH));
  assign w_slot  = cfg_en && (r_state == S_RUN)
                && (r_div_cnt == '0);
  // Flush wins over both ends; a slot hitting a flush is an underflow.
  assign w_push  = wr_valid && !w_full && !fifo_flush;
  assign w_pop   = w_slot && !w_empty && !fifo_flush;

  always_comb begin
    w_next = r_state;
    if (!cfg_en) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:   w_next = S_SETTLE;
        S_SETTLE: if (r_settle_cnt == '0) w_next = S_RUN;
        S_RUN:    w_next = S_RUN;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_div_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (cfg_en && r_state == S_IDLE) begin
        r_settle_cnt <= cfg_settle;
      end else if (cfg_en && r_state == S_SETTLE
                   && r_settle_cnt != '0) begin
        r_settle_cnt <= r_settle_cnt - SETTLE_W'(1);
      end
      if (cfg_en && r_state == S_SETTLE
          && r_settle_cnt == '0) begin
        r_div_cnt <= '0;
      end else if (cfg_en && r_state == S_RUN) begin
        r_div_cnt <= (r_div_cnt == '0) ? cfg_div
                   : r_div_cnt - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_dac_data  <= 8'h00;
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= w_slot && (w_empty || fifo_flush);
      if (fifo_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
        if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
      end
      if (w_pop) r_dac_data <= r_mem[r_rptr[AW-1:0]];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= wr_data;
  end

  assign wr_ready   = !w_full;
  assign fifo_level = w_level;
  assign dac_ena    = (r_state != S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign dac_data   = r_dac_data;
  assign underflow  = r_underflow;

endmodule
